ir_prefetch: RTL and testbench
==============================

// Module: ir_prefetch
// PURPOSE
//  Instruction prefetch buffer upstream of the IR register file. Streams sequential instruction
//  words from instruction memory over a req/ack handshake into a DEPTH-entry FIFO. Presents the
//  head word and its address to the IR stage. On a taken jump, flushes and redirects to the target.
// PARAMETERS
//  ADDR_W      16   instruction address width (word addressed)
//  DATA_W      16   instruction word width
//  DEPTH       4    FIFO entries; power of 2, >=2
//  RESET_ADDR  0    first fetch address after reset
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  i_flush       in   1       redirect pulse from the jump stage
//  i_flush_addr  in   ADDR_W  redirect target address
//  o_mem_req     out  1       instruction memory read request
//  o_mem_addr    out  ADDR_W  request address
//  i_mem_ack     in   1       read done; i_mem_data valid this cycle
//  i_mem_data    in   DATA_W  read data
//  o_ir_valid    out  1       FIFO head valid
//  o_ir          out  DATA_W  FIFO head word
//  o_ir_addr     out  ADDR_W  address of the head word
//  i_ir_ready    in   1       IR stage accepts the head word this cycle
// BEHAVIOUR
//  Reset: o_mem_req=0, o_mem_addr=RESET_ADDR, o_ir_valid=0, o_ir=0, o_ir_addr=0, FIFO empty,
//   fetch pc=RESET_ADDR, state=IDLE.
//  FSM: IDLE -> REQ when count+0 < DEPTH (space for one word). REQ drives o_mem_req=1,
//   o_mem_addr=pc. Address stays stable until i_mem_ack.
//   REQ & ack & !flush: push {pc,data}; pc<=pc+1 (wraps mod 2^ADDR_W); next state REQ if
//   post-push space remains, else IDLE.
//   REQ & flush (with or without ack): FIFO cleared; pc<=i_flush_addr; ack data is dropped.
//   If ack came in the same cycle, go to REQ at the new pc. Otherwise go to DISCARD.
//   DISCARD: req held at the old address until ack; data dropped; then REQ at the new pc.
//   A flush while in DISCARD updates pc only.
//   IDLE & flush: clear FIFO; pc<=i_flush_addr; next state REQ.
//  At most one request outstanding. The space check counts the outstanding request, so an ack
//   never finds the FIFO full.
//  Output: o_ir_valid = !empty. o_ir/o_ir_addr are the head entry (registered FIFO storage,
//   0 when empty). Pop on o_ir_valid & i_ir_ready.
//  Simultaneous push and pop: both happen; count is unchanged.
//  Flush and pop in the same cycle: flush wins; the popped word is discarded with the rest.
//  Latency: flush at cycle N, no request outstanding -> req at the target in N+1. With ack in
//   N+1, o_ir_valid is high in N+2. Zero-wait memory sustains 1 word per cycle.
//  Reset mid-transfer: immediate return to reset state; any pending ack after reset is ignored
//   in IDLE.
// CONFIGURATION
//  IR_PREFETCH_STATS_EN defined: adds output o_stall_cnt [15:0]. It increments each cycle with
//   i_ir_ready=1 & o_ir_valid=0 & !i_flush, saturates at 16'hFFFF, and resets to 0.
//  Undefined: no port, no counter logic.
// TESTING
//  1) Reset release; memory acks every req same cycle; i_ir_ready=1.
//     -> addresses 0,1,2,...; o_ir_addr 0,1,2 from cycle 2; one word per cycle.
//  2) i_ir_ready=0.
//     -> exactly 4 acks accepted; o_mem_req=0 thereafter; one pop re-enables req next cycle.
//  3) Memory ack delayed 3 cycles; flush to 0x0040 on cycle 1 of the wait.
//     -> req stays at the old address until ack; that data is dropped; next req is 0x0040;
//     -> first o_ir_addr=0x0040.
//  4) Flush to 0x0100 with i_ir_ready=1, valid=1 and ack in the same cycle.
//     -> no pop or push recorded; FIFO empty next cycle; req at 0x0100.
//  5) pc=0xFFFF with acks -> next request at 0x0000.
//  6) STATS_EN build: 10 starved ready cycles -> o_stall_cnt=10; rst -> 0.

Source files
------------

// File: rtl/ir_prefetch.sv
// Instruction prefetch buffer: streams sequential words over req/ack into a FIFO and handles jump redirects.
// Optional stall counter output is enabled by defining IR_PREFETCH_STATS_EN.
module ir_prefetch #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int DEPTH      = 4,
   parameter int RESET_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic [ADDR_W-1:0] i_flush_addr,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic              o_ir_valid,
   output logic [DATA_W-1:0] o_ir,
   output logic [ADDR_W-1:0] o_ir_addr,
   input  logic              i_ir_ready
`ifdef IR_PREFETCH_STATS_EN
   ,
   output logic [15:0]       o_stall_cnt
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [ADDR_W-1:0]   pc_r;
   logic [ADDR_W-1:0]   pc_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [ADDR_W-1:0]   addr_s;
   logic                mem_req_r;

   logic [DATA_W-1:0]   fifo_data_r [DEPTH];
   logic [ADDR_W-1:0]   fifo_addr_r [DEPTH];
   logic [PW-1:0]       wr_ptr_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_r;
   logic [CW-1:0]       count_next_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic                space_s;

   // FIFO handshake decode; a flush suppresses both push and pop
   always_comb begin
      empty_s      = (count_r == {CW{1'b0}});
      push_s       = (state_r == ST_REQ) && i_mem_ack && !i_flush;
      pop_s        = !empty_s && i_ir_ready && !i_flush;
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
      space_s      = (count_next_s < CW'(DEPTH));
   end

   // Next-state, fetch pc and request address
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      case (state_r)
         ST_IDLE: begin
            if (i_flush) begin
               pc_s    = i_flush_addr;
               state_s = ST_REQ;
            end else if (space_s) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (i_flush) begin
               pc_s    = i_flush_addr;
               state_s = i_mem_ack ? ST_REQ : ST_DISCARD;
            end else if (i_mem_ack) begin
               pc_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_s = space_s ? ST_REQ : ST_IDLE;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_DISCARD: begin
            if (i_flush) begin
               pc_s = i_flush_addr;
            end else begin
               pc_s = pc_r;
            end
            if (i_mem_ack) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_DISCARD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      // An abandoned request keeps its old address on the bus until it completes
      if (state_s == ST_DISCARD) begin
         addr_s = addr_r;
      end else begin
         addr_s = pc_s;
      end
   end

   // FSM, pc and memory request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pc_r      <= ADDR_W'(RESET_ADDR);
         addr_r    <= ADDR_W'(RESET_ADDR);
         mem_req_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         addr_r    <= addr_s;
         mem_req_r <= (state_s != ST_IDLE);
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (i_flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         count_r <= count_next_s;
      end
   end

   // FIFO storage: each entry holds the word and the address it was fetched from
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_r[i] <= {DATA_W{1'b0}};
            fifo_addr_r[i] <= {ADDR_W{1'b0}};
         end
      end else if (push_s) begin
         fifo_data_r[wr_ptr_r] <= i_mem_data;
         fifo_addr_r[wr_ptr_r] <= pc_r;
      end
   end

   assign o_mem_req  = mem_req_r;
   assign o_mem_addr = addr_r;
   assign o_ir_valid = !empty_s;
   assign o_ir       = empty_s ? {DATA_W{1'b0}} : fifo_data_r[rd_ptr_r];
   assign o_ir_addr  = empty_s ? {ADDR_W{1'b0}} : fifo_addr_r[rd_ptr_r];

`ifdef IR_PREFETCH_STATS_EN
   logic [15:0] stall_cnt_r;

   // Counts cycles the IR stage was ready but starved; saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 16'd0;
      end else if (i_ir_ready && empty_s && !i_flush && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end
   end

   assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ir_prefetch.sv
// Directed self-checking bench for ir_prefetch; stall counter checks compile only with IR_PREFETCH_STATS_EN.
module tb_ir_prefetch;

   logic        clk;
   logic        rst;
   logic        i_flush;
   logic [15:0] i_flush_addr;
   logic        o_mem_req;
   logic [15:0] o_mem_addr;
   logic        i_mem_ack;
   logic [15:0] i_mem_data;
   logic        o_ir_valid;
   logic [15:0] o_ir;
   logic [15:0] o_ir_addr;
   logic        i_ir_ready;
`ifdef IR_PREFETCH_STATS_EN
   logic [15:0] o_stall_cnt;
`endif

   int checks;
   int failures;

   ir_prefetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_ADDR(0)) dut (
      .clk(clk),
      .rst(rst),
      .i_flush(i_flush),
      .i_flush_addr(i_flush_addr),
      .o_mem_req(o_mem_req),
      .o_mem_addr(o_mem_addr),
      .i_mem_ack(i_mem_ack),
      .i_mem_data(i_mem_data),
      .o_ir_valid(o_ir_valid),
      .o_ir(o_ir),
      .o_ir_addr(o_ir_addr),
      .i_ir_ready(i_ir_ready)
`ifdef IR_PREFETCH_STATS_EN
      ,
      .o_stall_cnt(o_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      i_flush = 1'b0;
      i_flush_addr = 16'h0000;
      i_mem_ack = 1'b0;
      i_mem_data = 16'h0000;
      i_ir_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (o_mem_req !== 1'b0 || o_mem_addr !== 16'h0000 || o_ir_valid !== 1'b0 ||
          o_ir !== 16'h0000 || o_ir_addr !== 16'h0000) begin
         failures++;
         $display("FAIL reset_state: req=%b addr=%h valid=%b ir=%h ir_addr=%h, want 0/0000/0/0000/0000",
                  o_mem_req, o_mem_addr, o_ir_valid, o_ir, o_ir_addr);
      end
      tick();
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000) begin
         failures++;
         $display("FAIL first_req: req=%b addr=%h, want 1/0000", o_mem_req, o_mem_addr);
      end
      // asynchronous reset mid-transfer, then an ack arriving in IDLE is ignored
      rst = 1'b1;
      #1;
      checks++;
      if (o_mem_req !== 1'b0 || o_mem_addr !== 16'h0000) begin
         failures++;
         $display("FAIL reset_async: req=%b addr=%h, want 0/0000", o_mem_req, o_mem_addr);
      end
      i_mem_ack = 1'b1;
      i_mem_data = 16'hBEEF;
      rst = 1'b0;
      tick();
      i_mem_ack = 1'b0;
      checks++;
      if (o_ir_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000) begin
         failures++;
         $display("FAIL reset_idle_ack: valid=%b req=%b addr=%h, want 0/1/0000",
                  o_ir_valid, o_mem_req, o_mem_addr);
      end
   endtask

   task automatic test_stream;
      do_reset();
      i_ir_ready = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         i_mem_ack = o_mem_req;
         i_mem_data = o_mem_addr ^ 16'hA5A5;
         tick();
         checks++;
         if (o_ir_valid !== 1'b1 || o_ir_addr !== 16'(k) || o_ir !== (16'(k) ^ 16'hA5A5) ||
             o_mem_addr !== 16'(k + 1)) begin
            failures++;
            $display("FAIL stream_%0d: valid=%b ir_addr=%h ir=%h mem_addr=%h, want 1/%h/%h/%h",
                     k, o_ir_valid, o_ir_addr, o_ir, o_mem_addr, 16'(k), 16'(k) ^ 16'hA5A5, 16'(k + 1));
         end
      end
      i_mem_ack = 1'b0;
   endtask

   task automatic test_backpressure;
      int n;
      n = 0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         i_mem_ack = o_mem_req;
         i_mem_data = o_mem_addr ^ 16'hA5A5;
         if (o_mem_req) n++;
         tick();
      end
      i_mem_ack = 1'b0;
      checks++;
      if (n !== 4 || o_mem_req !== 1'b0 || o_ir_valid !== 1'b1 || o_ir_addr !== 16'h0000) begin
         failures++;
         $display("FAIL full_stop: acks=%0d req=%b valid=%b ir_addr=%h, want 4/0/1/0000",
                  n, o_mem_req, o_ir_valid, o_ir_addr);
      end
      i_ir_ready = 1'b1;
      tick();
      i_ir_ready = 1'b0;
      checks++;
      if (o_ir_addr !== 16'h0001 || o_mem_req !== 1'b1 || o_mem_addr !== 16'h0004) begin
         failures++;
         $display("FAIL pop_rearm: ir_addr=%h req=%b addr=%h, want 0001/1/0004",
                  o_ir_addr, o_mem_req, o_mem_addr);
      end
      i_mem_ack = 1'b1;
      i_mem_data = 16'h1234;
      tick();
      i_mem_ack = 1'b0;
      checks++;
      if (o_mem_req !== 1'b0 || o_ir_addr !== 16'h0001) begin
         failures++;
         $display("FAIL refill: req=%b ir_addr=%h, want 0/0001", o_mem_req, o_ir_addr);
      end
      i_flush = 1'b1;
      i_flush_addr = 16'h0200;
      tick();
      i_flush = 1'b0;
      checks++;
      if (o_ir_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 16'h0200) begin
         failures++;
         $display("FAIL idle_flush: valid=%b req=%b addr=%h, want 0/1/0200",
                  o_ir_valid, o_mem_req, o_mem_addr);
      end
      i_mem_ack = 1'b1;
      i_mem_data = 16'h5A00;
      tick();
      i_mem_ack = 1'b0;
      checks++;
      if (o_ir_valid !== 1'b1 || o_ir_addr !== 16'h0200 || o_ir !== 16'h5A00) begin
         failures++;
         $display("FAIL idle_flush_data: valid=%b ir_addr=%h ir=%h, want 1/0200/5A00",
                  o_ir_valid, o_ir_addr, o_ir);
      end
   endtask

   task automatic test_flush_discard;
      do_reset();
      i_ir_ready = 1'b1;
      tick();
      i_flush = 1'b1;
      i_flush_addr = 16'h0040;
      tick();
      i_flush = 1'b0;
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000) begin
         failures++;
         $display("FAIL discard_hold1: req=%b addr=%h, want 1/0000", o_mem_req, o_mem_addr);
      end
      tick();
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000) begin
         failures++;
         $display("FAIL discard_hold2: req=%b addr=%h, want 1/0000", o_mem_req, o_mem_addr);
      end
      i_mem_ack = 1'b1;
      i_mem_data = 16'hDEAD;
      tick();
      checks++;
      if (o_ir_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 16'h0040) begin
         failures++;
         $display("FAIL discard_drop: valid=%b req=%b addr=%h, want 0/1/0040",
                  o_ir_valid, o_mem_req, o_mem_addr);
      end
      i_mem_data = 16'hC040;
      tick();
      checks++;
      if (o_ir_valid !== 1'b1 || o_ir_addr !== 16'h0040 || o_ir !== 16'hC040) begin
         failures++;
         $display("FAIL discard_target: valid=%b ir_addr=%h ir=%h, want 1/0040/C040",
                  o_ir_valid, o_ir_addr, o_ir);
      end
   endtask

   task automatic test_flush_collision;
      // continues from test_flush_discard: head valid, req outstanding, ready high
      i_mem_ack = 1'b1;
      i_mem_data = 16'h7777;
      i_flush = 1'b1;
      i_flush_addr = 16'h0100;
      tick();
      i_flush = 1'b0;
      checks++;
      if (o_ir_valid !== 1'b0 || o_ir !== 16'h0000 || o_ir_addr !== 16'h0000 ||
          o_mem_req !== 1'b1 || o_mem_addr !== 16'h0100) begin
         failures++;
         $display("FAIL flush_collide: valid=%b ir=%h ir_addr=%h req=%b addr=%h, want 0/0000/0000/1/0100",
                  o_ir_valid, o_ir, o_ir_addr, o_mem_req, o_mem_addr);
      end
      i_mem_data = 16'h0A00;
      tick();
      i_mem_ack = 1'b0;
      checks++;
      if (o_ir_valid !== 1'b1 || o_ir_addr !== 16'h0100 || o_ir !== 16'h0A00) begin
         failures++;
         $display("FAIL flush_collide_next: valid=%b ir_addr=%h ir=%h, want 1/0100/0A00",
                  o_ir_valid, o_ir_addr, o_ir);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      i_ir_ready = 1'b1;
      tick();
      i_flush = 1'b1;
      i_flush_addr = 16'hFFFE;
      i_mem_ack = 1'b1;
      tick();
      i_flush = 1'b0;
      i_mem_data = 16'h1111;
      tick();
      i_mem_data = 16'h2222;
      tick();
      checks++;
      if (o_ir_addr !== 16'hFFFF || o_ir !== 16'h2222 || o_mem_addr !== 16'h0000) begin
         failures++;
         $display("FAIL wrap: ir_addr=%h ir=%h mem_addr=%h, want FFFF/2222/0000",
                  o_ir_addr, o_ir, o_mem_addr);
      end
      i_mem_data = 16'h3333;
      tick();
      i_mem_ack = 1'b0;
      checks++;
      if (o_ir_addr !== 16'h0000 || o_ir !== 16'h3333 || o_mem_addr !== 16'h0001) begin
         failures++;
         $display("FAIL wrap_next: ir_addr=%h ir=%h mem_addr=%h, want 0000/3333/0001",
                  o_ir_addr, o_ir, o_mem_addr);
      end
   endtask

`ifdef IR_PREFETCH_STATS_EN
   task automatic test_stats;
      do_reset();
      i_ir_ready = 1'b1;
      repeat (10) tick();
      checks++;
      if (o_stall_cnt !== 16'd10) begin
         failures++;
         $display("FAIL stall_cnt: got %0d, want 10", o_stall_cnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (o_stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL stall_cnt_reset: got %0d, want 0", o_stall_cnt);
      end
      rst = 1'b0;
      i_ir_ready = 1'b0;
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      i_flush = 1'b0;
      i_flush_addr = 16'h0000;
      i_mem_ack = 1'b0;
      i_mem_data = 16'h0000;
      i_ir_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_discard();
      test_flush_collision();
      test_wrap();
`ifdef IR_PREFETCH_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
